mem_access_ctrl: RTL and testbench

Memory-stage access controller that sits directly upstream of the data memory. It takes load and store requests from the execute stage and drives the synchronous single-port block RAM. The RAM has no byte enables, so sub-word stores are done as read-modify-write sequences. Loads return data aligned to the byte offset and extended according to funct3. Illegal or misaligned accesses are flagged without touching the RAM.

---
 rtl/mem_access_ctrl_pkg.sv | 38 +++
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_lane_fmt.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: FSM encodings,
// RISC-V funct3 load/store constants and the access legality check.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [2:0] L_BYTE   = 3'b000;
    localparam logic [2:0] L_HALF   = 3'b001;
    localparam logic [2:0] L_WORD   = 3'b010;
    localparam logic [2:0] L_BYTE_U = 3'b100;
    localparam logic [2:0] L_HALF_U = 3'b101;
    localparam logic [2:0] S_BYTE   = 3'b000;
    localparam logic [2:0] S_HALF   = 3'b001;
    localparam logic [2:0] S_WORD   = 3'b010;

    // Unsigned variants only exist for loads; halfwords need even and words zero offset.
    function automatic logic access_is_err(input logic we, input logic [2:0] funct,
                                           input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct)
            L_BYTE:   err = 1'b0;
            L_HALF:   err = off[0];
            L_WORD:   err = (off != 2'b00);
            L_BYTE_U: err = we;
            L_HALF_U: err = we | off[0];
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between the execute stage (master) and the controller (slave).
// A request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        access_err;

    modport master (
        output req_valid, req_we, req_funct, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, access_err
    );

    modport slave (
        input  req_valid, req_we, req_funct, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, access_err
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational byte/halfword lane logic: load extract + extend, and store merge
// of the addressed lane into the word read from RAM.
module mem_lane_fmt
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  off,
    input  logic [31:0] ram_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        unused_store_hi;

    assign unused_store_hi = ^store_data[31:16];

    always_comb begin
        byte_lane = ram_word[{off, 3'b000} +: 8];
        half_lane = off[1] ? ram_word[31:16] : ram_word[15:0];

        case (funct)
            L_BYTE:   load_data = {{24{byte_lane[7]}}, byte_lane};
            L_BYTE_U: load_data = {24'h0, byte_lane};
            L_HALF:   load_data = {{16{half_lane[15]}}, half_lane};
            L_HALF_U: load_data = {16'h0, half_lane};
            default:  load_data = ram_word;
        endcase

        merged_word = ram_word;
        if (funct == S_BYTE) begin
            merged_word[{off, 3'b000} +: 8] = store_data[7:0];
        end else if (funct == S_HALF) begin
            merged_word[{off[1], 4'b0000} +: 16] = store_data[15:0];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller driving a single-port synchronous RAM without
// byte enables; sub-word stores are done as read-modify-write.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output state_t            dbg_state
);

    state_t      state;
    logic        we_q;
    logic [2:0]  funct_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        access_err_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        accept;
    logic        unused_addr_hi;

    assign accept         = bus.req_valid && (state == ST_IDLE);
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    mem_lane_fmt u_lane_fmt (
        .funct       (funct_q),
        .off         (off_q),
        .ram_word    (ram_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // RAM strobes and resp_valid are registered on the transition into the state that owns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            we_q         <= 1'b0;
            funct_q      <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            resp_valid_q <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        funct_q  <= bus.req_funct;
                        off_q    <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata;
                        ram_addr <= bus.req_addr[ADDR_W+1:2];
                        if (access_is_err(bus.req_we, bus.req_funct, bus.req_addr[1:0])) begin
                            state        <= ST_ERR;
                            resp_valid_q <= 1'b1;
                            access_err_q <= 1'b1;
                        end else if (bus.req_we && bus.req_funct == S_WORD) begin
                            state        <= ST_WR;
                            ram_we       <= 1'b1;
                            ram_wdata    <= bus.req_wdata;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state  <= ST_RD;
                            ram_en <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state        <= ST_RD_DATA;
                    ram_en       <= 1'b0;
                    resp_valid_q <= !we_q;
                end
                ST_RD_DATA: begin
                    if (we_q) begin
                        state        <= ST_WR;
                        ram_we       <= 1'b1;
                        ram_wdata    <= merged_word;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state        <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                ST_WR: begin
                    state        <= ST_IDLE;
                    ram_we       <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
                ST_ERR: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    access_err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load data comes straight from the RAM output register during RD_DATA.
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.access_err = access_err_q;
    assign bus.resp_rdata = (state == ST_RD_DATA && !we_q) ? load_data : 32'h0;
    assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural one-cycle-latency RAM.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    state_t            dbg_state;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int en_count = 0;
    int we_count = 0;
    int acc_count = 0;
    always @(posedge clk) begin
        if (ram_en) en_count++;
        if (ram_we) we_count++;
        if (bus.req_valid && bus.req_ready) acc_count++;
    end

    logic [31:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic drive_req(input logic we, input logic [2:0] funct,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_funct = funct;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [41:0] got;
        logic [41:0] exp;
        got = {bus.req_ready, bus.resp_valid, bus.access_err, ram_en, ram_we, ram_addr, 27'h0};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 27'h0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h expected %h", got, exp);
        end
        tests_run++;
        if (bus.resp_rdata !== 32'h0 || ram_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata %h wdata %h expected 0 0", bus.resp_rdata, ram_wdata);
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_load();
        logic [2:0]  f [5];
        logic [31:0] a [5];
        logic [31:0] e [5];
        f = '{L_BYTE, L_HALF_U, L_HALF, L_BYTE_U, L_WORD};
        a = '{32'h0D, 32'h0E, 32'h0C, 32'h0F, 32'h0C};
        e = '{32'hFFFF_FFAA, 32'h0000_8899, 32'hFFFF_AABB, 32'h0000_0088, 32'h8899_AABB};
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b0, f[i], a[i], 32'h0);
            tests_run++;
            if (ram_en !== 1'b1 || ram_addr !== 10'd3 || bus.resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_rd[%0d]: got en %b addr %0d resp %b expected 1 3 0",
                         i, ram_en, ram_addr, bus.resp_valid);
            end
            next_cycle();
            tests_run++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e[i] || bus.access_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_resp[%0d]: got valid %b data %h err %b expected 1 %h 0",
                         i, bus.resp_valid, bus.resp_rdata, bus.access_err, e[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int n_resp;
        int resp_c [2];
        logic [31:0] exp_v;
        a0 = acc_count;
        n_resp = 0;
        resp_c = '{0, 0};
        exp_q.push_back(32'hFFFF_FFAA);
        exp_q.push_back(32'h0000_8899);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_funct = L_BYTE;
        bus.req_addr  = 32'h0D;
        @(posedge clk);
        #1;
        bus.req_funct = L_HALF_U;
        bus.req_addr  = 32'h0E;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            if (c == 4) bus.req_valid = 1'b0;
            if (c == 3) begin
                tests_run++;
                if (bus.req_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready: got %b expected 1", bus.req_ready);
                end
            end
            if (bus.resp_valid === 1'b1) begin
                if (n_resp < 2) resp_c[n_resp] = c;
                n_resp++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                tests_run++;
                if (bus.resp_rdata !== exp_v) begin
                    tests_failed++;
                    $display("FAIL b2b_data: got %h expected %h", bus.resp_rdata, exp_v);
                end
            end
        end
        tests_run++;
        if (n_resp != 2 || resp_c[0] != 2 || resp_c[1] != 5) begin
            tests_failed++;
            $display("FAIL b2b_timing: got %0d resps at %0d,%0d expected 2 at 2,5",
                     n_resp, resp_c[0], resp_c[1]);
        end
        tests_run++;
        if (acc_count - a0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_accepts: got %0d expected 2", acc_count - a0);
        end
        exp_q.delete();
    endtask

    task automatic test_store_sub();
        logic [2:0]  f [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [31:0] e [2];
        f = '{S_BYTE, S_HALF};
        a = '{32'h0D, 32'h0E};
        d = '{32'hABCD_EF12, 32'h0000_5566};
        e = '{32'h8899_12BB, 32'h5566_12BB};
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b1, f[i], a[i], d[i]);
            tests_run++;
            if (ram_en !== 1'b1 || ram_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL st_rd[%0d]: got en %b we %b expected 1 0", i, ram_en, ram_we);
            end
            next_cycle();
            tests_run++;
            if (ram_en !== 1'b0 || ram_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL st_rd_data[%0d]: got en %b we %b resp %b expected 0 0 0",
                         i, ram_en, ram_we, bus.resp_valid);
            end
            next_cycle();
            tests_run++;
            if (ram_we !== 1'b1 || ram_addr !== 10'd3 || ram_wdata !== e[i] || bus.resp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL st_wr[%0d]: got we %b addr %0d wdata %h resp %b expected 1 3 %h 1",
                         i, ram_we, ram_addr, ram_wdata, bus.resp_valid, e[i]);
            end
            next_cycle();
            drive_req(1'b0, L_WORD, 32'h0C, 32'h0);
            next_cycle();
            tests_run++;
            if (bus.resp_rdata !== e[i]) begin
                tests_failed++;
                $display("FAIL st_readback[%0d]: got %h expected %h", i, bus.resp_rdata, e[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_store_word();
        int e0;
        e0 = en_count;
        drive_req(1'b1, S_WORD, 32'h10, 32'hDEAD_BEEF);
        tests_run++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd4 || ram_wdata !== 32'hDEAD_BEEF ||
            bus.resp_valid !== 1'b1 || ram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_wr: got we %b addr %0d wdata %h resp %b en %b expected 1 4 deadbeef 1 0",
                     ram_we, ram_addr, ram_wdata, bus.resp_valid, ram_en);
        end
        next_cycle();
        tests_run++;
        if (ram_we !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || en_count != e0) begin
            tests_failed++;
            $display("FAIL sw_done: got we %b resp %b ready %b en_cycles %0d expected 0 0 1 0",
                     ram_we, bus.resp_valid, bus.req_ready, en_count - e0);
        end
        // Upper address bits must be dropped: 0x1010 aliases word 4.
        drive_req(1'b0, L_WORD, 32'h1010, 32'h0);
        tests_run++;
        if (ram_addr !== 10'd4) begin
            tests_failed++;
            $display("FAIL wrap_addr: got %0d expected 4", ram_addr);
        end
        next_cycle();
        tests_run++;
        if (bus.resp_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL wrap_data: got %h expected deadbeef", bus.resp_rdata);
        end
        next_cycle();
    endtask

    task automatic test_errors();
        logic        w [4];
        logic [2:0]  f [4];
        logic [31:0] a [4];
        int e0;
        int w0;
        w = '{1'b0, 1'b1, 1'b0, 1'b1};
        f = '{L_WORD, S_HALF, 3'b011, L_BYTE_U};
        a = '{32'h0E, 32'h01, 32'h00, 32'h00};
        for (int i = 0; i < 4; i++) begin
            e0 = en_count;
            w0 = we_count;
            drive_req(w[i], f[i], a[i], 32'hFFFF_FFFF);
            tests_run++;
            if (bus.resp_valid !== 1'b1 || bus.access_err !== 1'b1 || ram_en !== 1'b0 ||
                ram_we !== 1'b0 || bus.resp_rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL err_resp[%0d]: got valid %b err %b en %b we %b data %h expected 1 1 0 0 0",
                         i, bus.resp_valid, bus.access_err, ram_en, ram_we, bus.resp_rdata);
            end
            next_cycle();
            tests_run++;
            if (bus.resp_valid !== 1'b0 || bus.access_err !== 1'b0 || bus.req_ready !== 1'b1 ||
                en_count != e0 || we_count != w0) begin
                tests_failed++;
                $display("FAIL err_done[%0d]: got valid %b err %b ready %b en %0d we %0d expected 0 0 1 0 0",
                         i, bus.resp_valid, bus.access_err, bus.req_ready, en_count - e0, we_count - w0);
            end
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        w0 = we_count;
        drive_req(1'b1, S_BYTE, 32'h0D, 32'h77);
        next_cycle();
        tests_run++;
        if (dbg_state !== ST_RD_DATA) begin
            tests_failed++;
            $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_RD_DATA);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (ram_we !== 1'b0 || bus.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL abort_reset: got we %b ready %b state %0d expected 0 1 0",
                     ram_we, bus.req_ready, dbg_state);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (we_count != w0) begin
            tests_failed++;
            $display("FAIL abort_we: got %0d write cycles expected 0", we_count - w0);
        end
        drive_req(1'b0, L_WORD, 32'h0C, 32'h0);
        next_cycle();
        tests_run++;
        if (bus.resp_rdata !== 32'h5566_12BB) begin
            tests_failed++;
            $display("FAIL abort_readback: got %h expected 556612bb", bus.resp_rdata);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_funct = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[3] = 32'h8899_AABB;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_load();
        test_back_to_back();
        test_store_sub();
        test_store_word();
        test_errors();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
